// File: rtl/step_value_ctrl_pkg.sv
// Shared types for the step/value controller: FSM states and step direction.
package step_value_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

endpackage

// File: rtl/step_value_alu.sv
// Combinational bounded step: adds/subtracts a step with clamp-or-wrap at the
// bounds, and also clamps an arbitrary input into range when stepped by zero.
module step_value_alu
  import step_value_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b0
) (
  input  logic [WIDTH-1:0] i_value,
  input  dir_t             i_dir,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_minVal,
  input  logic [WIDTH-1:0] i_maxVal,
  output logic [WIDTH-1:0] o_next,
  output logic             o_change
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_floor;
  logic [WIDTH:0] w_diff;

  // One extra bit keeps overflow/underflow visible before comparing to bounds.
  always_comb begin
    w_sum   = {1'b0, i_value} + {1'b0, i_step};
    w_floor = {1'b0, i_minVal} + {1'b0, i_step};
    w_diff  = {1'b0, i_value} - {1'b0, i_step};
    o_next  = i_value;
    if (i_dir == DIR_UP) begin
      if (w_sum > {1'b0, i_maxVal}) begin
        o_next = (WRAP && (i_value == i_maxVal)) ? i_minVal : i_maxVal;
      end else if (w_sum < {1'b0, i_minVal}) begin
        o_next = i_minVal;
      end else begin
        o_next = w_sum[WIDTH-1:0];
      end
    end else begin
      if ({1'b0, i_value} < w_floor) begin
        o_next = (WRAP && (i_value == i_minVal)) ? i_maxVal : i_minVal;
      end else if (w_diff > {1'b0, i_maxVal}) begin
        o_next = i_maxVal;
      end else begin
        o_next = w_diff[WIDTH-1:0];
      end
    end
  end

  assign o_change = (o_next != i_value);

endmodule

// File: rtl/step_value_ctrl.sv
// Turns up/down auto-repeat step pulses into a bounded setting, with single
// steps at first and coarse steps once a button has been held long enough.
module step_value_ctrl
  import step_value_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 99,
  parameter int ACCEL_CNT = 4,
  parameter int FAST_STEP = 10,
  parameter bit WRAP      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_btn,
  input  logic             dn_btn,
  input  logic             up_pulse,
  input  logic             dn_pulse,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             fast,
  output logic             at_limit
);

  localparam int               CW      = $clog2(ACCEL_CNT + 1);
  localparam logic [WIDTH-1:0] C_MIN   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] C_MAX   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_FAST  = WIDTH'(FAST_STEP);
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
  localparam logic [CW-1:0]    C_ACCEL = CW'(ACCEL_CNT);

  state_t           r_state;
  state_t           w_stateNext;
  dir_t             r_dir;
  dir_t             w_dirNext;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_countNext;
  logic [CW-1:0]    w_countInc;
  logic [WIDTH-1:0] r_value;
  logic             r_changed;
  logic             r_fast;

  logic             w_dirHeld;
  logic             w_accept;
  dir_t             w_aluDir;
  logic [WIDTH-1:0] w_aluValue;
  logic [WIDTH-1:0] w_aluStep;
  logic [WIDTH-1:0] w_aluNext;
  logic             w_aluChange;
  logic [WIDTH-1:0] w_valueNext;

  assign w_dirHeld  = (r_dir == DIR_UP) ? up_btn : dn_btn;
  assign w_countInc = r_count + CW'(1);

  // Load wins over pulses, so a pulse in a load cycle is neither stepped nor counted.
  assign w_accept = (r_state != IDLE) && (up_pulse ^ dn_pulse) && !load &&
                    ((r_dir == DIR_UP) ? up_pulse : dn_pulse);

  // The ALU is shared: a zero step downwards clamps load_val into range.
  assign w_aluValue = load ? load_val : r_value;
  assign w_aluDir   = load ? DIR_DN : r_dir;
  assign w_aluStep  = load ? '0 : ((r_state == FAST) ? C_FAST : C_ONE);

  step_value_alu #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_alu (
    .i_value  (w_aluValue),
    .i_dir    (w_aluDir),
    .i_step   (w_aluStep),
    .i_minVal (C_MIN),
    .i_maxVal (C_MAX),
    .o_next   (w_aluNext),
    .o_change (w_aluChange)
  );

  assign w_valueNext = (load || (w_accept && w_aluChange)) ? w_aluNext : r_value;

  always_comb begin
    w_stateNext = r_state;
    w_dirNext   = r_dir;
    w_countNext = r_count;
    unique case (r_state)
      IDLE: begin
        if (up_btn && !dn_btn) begin
          w_stateNext = SLOW;
          w_dirNext   = DIR_UP;
        end else if (dn_btn && !up_btn) begin
          w_stateNext = SLOW;
          w_dirNext   = DIR_DN;
        end
      end
      SLOW, FAST: begin
        if (!w_dirHeld || (up_btn && dn_btn)) begin
          w_stateNext = IDLE;
          w_countNext = '0;
        end else if (w_accept && (r_state == SLOW)) begin
          w_countNext = w_countInc;
          if (w_countInc == C_ACCEL) begin
            w_stateNext = FAST;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_countNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_dir   <= DIR_UP;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_dir   <= w_dirNext;
      r_count <= w_countNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value   <= C_MIN;
      r_changed <= 1'b0;
      r_fast    <= 1'b0;
    end else begin
      r_value   <= w_valueNext;
      r_changed <= (w_valueNext != r_value);
      r_fast    <= (w_stateNext == FAST);
    end
  end

  assign value    = r_value;
  assign changed  = r_changed;
  assign fast     = r_fast;
  assign at_limit = (r_value == C_MIN) || (r_value == C_MAX);

endmodule

// File: tb/tb_step_value_ctrl.sv
// Bench for step_value_ctrl: a saturating and a wrapping instance share one
// directed stimulus; an integer model is compared every cycle, plus literal checks.
module tb_step_value_ctrl;

  localparam int MIN_VAL   = 0;
  localparam int MAX_VAL   = 99;
  localparam int ACCEL_CNT = 4;
  localparam int FAST_STEP = 10;

  logic       clock = 1'b0;
  logic       rstN;
  logic       upBtn;
  logic       dnBtn;
  logic       upPulse;
  logic       dnPulse;
  logic       loadStb;
  logic [7:0] loadVal;
  logic [7:0] valueOut   [2];
  logic       changedOut [2];
  logic       fastOut    [2];
  logic       atLimitOut [2];

  int checks   = 0;
  int failures = 0;

  int mMode [2] = '{0, 0};
  int mDir  [2] = '{0, 0};
  int mCnt  [2] = '{0, 0};
  int mVal  [2] = '{0, 0};
  int mChg  [2] = '{0, 0};

  always #5 clock = ~clock;

  step_value_ctrl #(
    .WIDTH(8), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
    .ACCEL_CNT(ACCEL_CNT), .FAST_STEP(FAST_STEP), .WRAP(1'b0)
  ) dut0 (
    .clk(clock), .rst(rstN), .up_btn(upBtn), .dn_btn(dnBtn),
    .up_pulse(upPulse), .dn_pulse(dnPulse), .load(loadStb), .load_val(loadVal),
    .value(valueOut[0]), .changed(changedOut[0]), .fast(fastOut[0]), .at_limit(atLimitOut[0])
  );

  step_value_ctrl #(
    .WIDTH(8), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
    .ACCEL_CNT(ACCEL_CNT), .FAST_STEP(FAST_STEP), .WRAP(1'b1)
  ) dut1 (
    .clk(clock), .rst(rstN), .up_btn(upBtn), .dn_btn(dnBtn),
    .up_pulse(upPulse), .dn_pulse(dnPulse), .load(loadStb), .load_val(loadVal),
    .value(valueOut[1]), .changed(changedOut[1]), .fast(fastOut[1]), .at_limit(atLimitOut[1])
  );

  // Bounded step written straight from the clamp/wrap rules.
  function automatic int stepModel(input int v, input bit goUp, input int step, input bit wrap);
    if (goUp) begin
      if (v + step > MAX_VAL) return (wrap && v == MAX_VAL) ? MIN_VAL : MAX_VAL;
      return v + step;
    end
    if (v - step < MIN_VAL) return (wrap && v == MIN_VAL) ? MAX_VAL : MIN_VAL;
    return v - step;
  endfunction

  function automatic int clampModel(input int v);
    if (v < MIN_VAL) return MIN_VAL;
    if (v > MAX_VAL) return MAX_VAL;
    return v;
  endfunction

  // Model: mode 0 idle, 1 slow, 2 fast; dir 0 up, 1 down. Instance i wraps iff i==1.
  always @(posedge clock or negedge rstN) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstN) begin
        mMode[i] = 0; mDir[i] = 0; mCnt[i] = 0; mVal[i] = MIN_VAL; mChg[i] = 0;
      end else begin
        int  prev;
        int  nv;
        bit  acc;
        bit  held;
        prev = mVal[i];
        nv   = prev;
        acc  = (mMode[i] != 0) && (upPulse != dnPulse) && !loadStb &&
               ((mDir[i] == 0) ? upPulse : dnPulse);
        if (loadStb) nv = clampModel(int'(loadVal));
        else if (acc) nv = stepModel(prev, mDir[i] == 0, (mMode[i] == 2) ? FAST_STEP : 1, i == 1);
        if (mMode[i] == 0) begin
          if (upBtn && !dnBtn) begin mMode[i] = 1; mDir[i] = 0; end
          else if (dnBtn && !upBtn) begin mMode[i] = 1; mDir[i] = 1; end
        end else begin
          held = (mDir[i] == 0) ? upBtn : dnBtn;
          if (!held || (upBtn && dnBtn)) begin
            mMode[i] = 0; mCnt[i] = 0;
          end else if (acc && mMode[i] == 1) begin
            mCnt[i]++;
            if (mCnt[i] == ACCEL_CNT) mMode[i] = 2;
          end
        end
        mChg[i] = (nv != prev) ? 1 : 0;
        mVal[i] = nv;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("model value[%0d]", i), int'(valueOut[i]), mVal[i]);
      checkOutput($sformatf("model changed[%0d]", i), int'(changedOut[i]), mChg[i]);
      checkOutput($sformatf("model fast[%0d]", i), int'(fastOut[i]), (mMode[i] == 2) ? 1 : 0);
      checkOutput($sformatf("model at_limit[%0d]", i), int'(atLimitOut[i]),
                  (mVal[i] == MIN_VAL || mVal[i] == MAX_VAL) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Drives one-cycle pulse/load inputs for a single edge, then clears them.
  task automatic applyStimulus(input logic upP, input logic dnP, input logic ld, input int ldV);
    upPulse = upP;
    dnPulse = dnP;
    loadStb = ld;
    loadVal = 8'(ldV);
    tick(1);
    upPulse = 1'b0;
    dnPulse = 1'b0;
    loadStb = 1'b0;
  endtask

  int accelExp [6] = '{1, 2, 3, 4, 14, 24};

  initial begin
    rstN = 1'b0; upBtn = 1'b0; dnBtn = 1'b0;
    upPulse = 1'b0; dnPulse = 1'b0; loadStb = 1'b0; loadVal = 8'd0;
    tick(3);
    checkOutput("reset value", int'(valueOut[0]), 0);
    checkOutput("reset changed", int'(changedOut[0]), 0);
    checkOutput("reset fast", int'(fastOut[0]), 0);
    checkOutput("reset at_limit", int'(atLimitOut[0]), 1);
    rstN = 1'b1;
    tick(1);

    // Acceleration run: four single steps, then coarse steps.
    upBtn = 1'b1;
    tick(1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      checkOutput($sformatf("accel value %0d", k), int'(valueOut[0]), accelExp[k]);
      checkOutput($sformatf("accel changed %0d", k), int'(changedOut[0]), 1);
      checkOutput($sformatf("accel fast %0d", k), int'(fastOut[0]), (k >= 3) ? 1 : 0);
      tick(4);
    end

    // Load near the top, then saturate or wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 90);
    checkOutput("load 90", int'(valueOut[0]), 90);
    checkOutput("load keeps fast", int'(fastOut[0]), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    checkOutput("clamp to max", int'(valueOut[0]), 99);
    checkOutput("at_limit at max", int'(atLimitOut[0]), 1);
    checkOutput("clamp to max wrap inst", int'(valueOut[1]), 99);
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    checkOutput("saturated value", int'(valueOut[0]), 99);
    checkOutput("saturated changed", int'(changedOut[0]), 0);
    checkOutput("wrap max to min", int'(valueOut[1]), 0);
    checkOutput("wrap changed", int'(changedOut[1]), 1);

    // Reverse through IDLE, then step down.
    upBtn = 1'b0;
    tick(2);
    dnBtn = 1'b1;
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("down step sat inst", int'(valueOut[0]), 98);
    checkOutput("wrap min to max", int'(valueOut[1]), 99);
    applyStimulus(1'b0, 1'b0, 1'b1, 95);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("down slow value", int'(valueOut[0]), 92);
    checkOutput("down fast entered", int'(fastOut[0]), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("clamp to min", int'(valueOut[0]), 0);
    checkOutput("clamp to min not wrap", int'(valueOut[1]), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("at min changed", int'(changedOut[0]), 0);
    checkOutput("wrap from min", int'(valueOut[1]), 99);

    // Ignored simultaneous pulses, and load priority with clamp.
    dnBtn = 1'b0;
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 50);
    upBtn = 1'b1;
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    checkOutput("both pulses value", int'(valueOut[0]), 50);
    checkOutput("both pulses changed", int'(changedOut[0]), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 150);
    checkOutput("load clamp 150", int'(valueOut[0]), 99);
    checkOutput("load clamp changed", int'(changedOut[0]), 1);

    // FAST up, release, press down: back to single steps.
    applyStimulus(1'b0, 1'b0, 1'b1, 40);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 0);
    checkOutput("fast again value", int'(valueOut[0]), 44);
    checkOutput("fast again", int'(fastOut[0]), 1);
    upBtn = 1'b0;
    tick(1);
    checkOutput("release clears fast", int'(fastOut[0]), 0);
    dnBtn = 1'b1;
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("reverse single step", int'(valueOut[0]), 43);
    checkOutput("reverse slow", int'(fastOut[0]), 0);

    // Asynchronous reset in the middle of a FAST run.
    dnBtn = 1'b0;
    tick(2);
    upBtn = 1'b1;
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 36);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 0);
    checkOutput("pre-reset value", int'(valueOut[0]), 40);
    #1 rstN = 1'b0;
    #1;
    checkOutput("async reset value", int'(valueOut[0]), 0);
    checkOutput("async reset fast", int'(fastOut[0]), 0);
    checkOutput("async reset changed", int'(changedOut[0]), 0);
    tick(1);
    rstN = 1'b1;
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    checkOutput("post-reset step", int'(valueOut[0]), 1);
    checkOutput("post-reset changed", int'(changedOut[0]), 1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_value_ctrl.md
Name: step_value_ctrl

Overview:
Consumes the periodic one-cycle step pulses produced by our button auto-repeat blocks (one instance for up, one for down) and turns them into a bounded numeric setting, e.g. a display or PWM duty value. It applies acceleration: slow single steps at first, then coarse steps after a run of repeats while the button stays held. It sits between the button/auto-repeat front end and the display/consumer logic.

Parameters:
WIDTH, 8, bit width of value.
MIN_VAL, 0, lower bound of value (also reset value).
MAX_VAL, 99, upper bound of value; MIN_VAL < MAX_VAL < 2**WIDTH.
ACCEL_CNT, 4, accepted pulses in SLOW before entering FAST (>= 1).
FAST_STEP, 10, step size in FAST (1 <= FAST_STEP <= MAX_VAL-MIN_VAL).
WRAP, 0, 0 = saturate at bounds; 1 = wrap to the opposite bound.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
up_btn  in  1  debounced up-button level, high = held
dn_btn  in  1  debounced down-button level, high = held
up_pulse  in  1  one-cycle step request from the up auto-repeat block
dn_pulse  in  1  one-cycle step request from the down auto-repeat block
load  in  1  one-cycle load strobe
load_val  in  WIDTH  value to load
value  out  WIDTH  current setting
changed  out  1  one-cycle strobe, high in the cycle value holds a new value
fast  out  1  high while in FAST state
at_limit  out  1  value == MIN_VAL or value == MAX_VAL

Behaviour:
- Reset (rst low, async): value=MIN_VAL, changed=0, fast=0, state=IDLE, dir=up, pulse count=0. at_limit follows from value (1 at reset).
- All decisions are made on the rising clk edge. Results are registered, so value/changed update in the cycle after the pulse is sampled. Latency is 1 cycle.
- State machine, with state, dir and a pulse counter (width $clog2(ACCEL_CNT+1)):
  - IDLE -> SLOW, dir=up: when up_btn=1 and dn_btn=0. Symmetrically for down.
  - SLOW: an accepted pulse steps by 1 and increments the count. The pulse that brings the count to ACCEL_CNT is still a 1-step; the next state is FAST.
  - FAST: each accepted pulse steps by FAST_STEP.
  - SLOW/FAST -> IDLE: when the dir button is released or both buttons are high. The count is cleared and fast=0 in the same edge.
  - No direct SLOW/FAST dir reversal: IDLE is always traversed, at least one cycle.
- Pulse acceptance: a pulse counts only when its button matches dir and the state is SLOW/FAST.
  - Ignored: pulses in IDLE, pulses against dir, and cycles with up_pulse=dn_pulse=1. An ignored pulse causes no value change and no count change.
- Arithmetic: computed in WIDTH+1 bits, no truncation before compare.
  - Up: next = value + step.
    - If next > MAX_VAL and WRAP=0: value = MAX_VAL.
    - If next > MAX_VAL and WRAP=1: value = MIN_VAL when value == MAX_VAL before the step, else MAX_VAL.
  - Down mirrors this with MIN_VAL and subtraction (check underflow before subtracting).
  - In other words, wrap only occurs from exactly the bound; otherwise the step clamps to the bound first.
- changed=1 only when the registered value actually differs from the previous value. A step already at a saturated bound gives changed=0.
- load has priority over any pulse in the same cycle:
  - value = load_val clamped to [MIN_VAL, MAX_VAL].
  - changed as per the rule above.
  - State and count are unaffected.
- fast is a registered decode of state == FAST.

Decomposition:
- Shared package: state enum (IDLE, SLOW, FAST) and a direction typedef (DIR_UP, DIR_DN).
- Natural sub-module: step_value_alu, purely combinational.
  - Inputs: value, dir, step, bounds, WRAP.
  - Outputs: next value and a "would change" flag.
  - It is reused for the load clamp path.
- Top level holds the FSM, counter and output registers.

Test Plan:
1. rst low for 3 cycles, then release; check outputs. Hold up_btn, send 6 up_pulse spaced 5 cycles apart starting from 0 -> value 1,2,3,4,14,24. fast rises after the 4th pulse. changed=1 for exactly one cycle per step.
2. load=1 with load_val=90, then up held in FAST (after 4 pulses, value 94) -> next pulse gives 99 with at_limit=1. A further pulse leaves value 99 with changed=0.
3. WRAP=1, value 99, up held, one pulse -> 0. Then dn held, one pulse -> 99. Then with value 95 in FAST down sequence (value 5): next pulse -> 0, not a wrap.
4. up_btn held, up_pulse and dn_pulse high in the same cycle -> no change. Assert load with load_val=150 and up_pulse together -> value 99 (clamped), no extra step.
5. Reach FAST going up, release up_btn for 1 cycle, press dn_btn -> state goes IDLE, then SLOW. fast=0 and next dn_pulse steps by 1.
6. Reach FAST with value 40, assert rst low mid-operation -> value=0, fast=0, changed=0 immediately (asynchronously). After release, an up pulse with up_btn held steps by 1.
